pixel_config_serializer: RTL

- Next-generation MIC4 pixel-configuration serializer: pops words from the config FIFO and shifts them into the chip over S_CLK/S_DATA while the chip is not BUSY.
- New versus the current generation:
  - Registered, divided S_CLK (no gated ~CLK_IN).
  - Parametrised width, shift direction, clock divider and inter-word gap.
  - Readback capture of the chip's serial output, abort, word counter and completion pulse.
- Sits between the config FIFO / control_interface pulse registers and the MIC4 pixel-config pins.

---
 rtl/pixel_config_pkg.sv | 25 ++
 rtl/pixel_sclk_gen.sv | 81 ++++++++
 rtl/pixel_config_serializer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/pixel_config_pkg.sv
// Shared types and helpers for the MIC4 pixel-configuration serializer.
package pixel_config_pkg;

   typedef enum logic [6:0] {
      IDLE  = 7'b000_0001,
      CHECK = 7'b000_0010,
      READ  = 7'b000_0100,
      LAT   = 7'b000_1000,
      LOAD  = 7'b001_0000,
      SHIFT = 7'b010_0000,
      GAP   = 7'b100_0000
   } state_t;

   localparam int GAP_CNT_W = 8;

   function automatic int clog2(input int value);
      int result;
      result = 32'sd0;
      while ((32'sd1 << result) < value) begin
         result = result + 32'sd1;
      end
      return result;
   endfunction

endpackage

// File: rtl/pixel_sclk_gen.sv
// S_CLK divider and bit-phase generator: low half then high half per bit,
// with strobes telling the serializer when the next edge falls, rises or ends the word.
module pixel_sclk_gen
   import pixel_config_pkg::*;
#(
   parameter int DATA_WIDTH = 15,
   parameter int CLK_DIV    = 1
) (
   input  logic CLK_IN,
   input  logic RESET,
   input  logic start,
   input  logic enable,
   input  logic abort,
   output logic fall_stb,
   output logic rise_stb,
   output logic last_bit_stb,
   output logic s_clk
);

   localparam int BIT_W = clog2(DATA_WIDTH);
   localparam int DIV_W = (clog2(CLK_DIV) > 32'sd1) ? clog2(CLK_DIV) : 32'sd1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 32'sd1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 32'sd1);

   logic [DIV_W-1:0] div_r;
   logic [BIT_W-1:0] bit_r;
   logic             high_r;
   logic             div_end_s;
   logic             bit_end_s;

   assign div_end_s    = (div_r == DIV_LAST);
   assign bit_end_s    = (bit_r == BIT_LAST);
   assign rise_stb     = enable & div_end_s & ~high_r;
   assign last_bit_stb = enable & div_end_s & high_r & bit_end_s;
   // start drops S_CLK for the first bit on the same edge that enters SHIFT
   assign fall_stb     = start | (enable & div_end_s & high_r & ~bit_end_s);

   // Divider, half-phase and bit counters plus the registered S_CLK.
   always_ff @(posedge CLK_IN or posedge RESET) begin
      if (RESET) begin
         div_r  <= '0;
         bit_r  <= '0;
         high_r <= 1'b0;
         s_clk  <= 1'b1;
      end else if (abort) begin
         div_r  <= '0;
         bit_r  <= '0;
         high_r <= 1'b0;
         s_clk  <= 1'b1;
      end else if (start) begin
         div_r  <= '0;
         bit_r  <= '0;
         high_r <= 1'b0;
         s_clk  <= 1'b0;
      end else if (enable) begin
         if (div_end_s) begin
            div_r <= '0;
            if (high_r) begin
               high_r <= 1'b0;
               if (bit_end_s) begin
                  s_clk <= 1'b1;
               end else begin
                  bit_r <= bit_r + BIT_W'(1'b1);
                  s_clk <= 1'b0;
               end
            end else begin
               high_r <= 1'b1;
               s_clk  <= 1'b1;
            end
         end else begin
            div_r <= div_r + DIV_W'(1'b1);
         end
      end else begin
         div_r  <= '0;
         bit_r  <= '0;
         high_r <= 1'b0;
         s_clk  <= 1'b1;
      end
   end

endmodule

// File: rtl/pixel_config_serializer.sv
// MIC4 pixel-configuration serializer: pops FIFO words and shifts them out over
// S_CLK/S_DATA between BUSY checks, capturing the chip's serial readback.
module pixel_config_serializer
   import pixel_config_pkg::*;
#(
   parameter int DATA_WIDTH      = 15,
   parameter bit SHIFT_DIRECTION = 1'b1,
   parameter int CLK_DIV         = 1,
   parameter int WORD_GAP        = 0,
   parameter int WCNT_WIDTH      = 16
) (
   input  logic                  CLK_IN,
   input  logic                  RESET,
   input  logic                  START,
   input  logic                  STOP,
   input  logic [DATA_WIDTH-1:0] DATA_IN,
   input  logic                  EMPTY,
   input  logic                  BUSY,
   input  logic                  S_DIN,
   output logic                  RD_FIFO,
   output logic                  S_CLK,
   output logic                  S_DATA,
   output logic [DATA_WIDTH-1:0] RB_DATA,
   output logic                  RB_VALID,
   output logic [WCNT_WIDTH-1:0] WORD_CNT,
   output logic                  ACTIVE,
   output logic                  DONE
);

   localparam logic [GAP_CNT_W-1:0] GAP_LAST =
      (WORD_GAP > 32'sd0) ? GAP_CNT_W'(WORD_GAP - 32'sd1) : {GAP_CNT_W{1'b0}};

   state_t                 state_r;
   logic [DATA_WIDTH-1:0]  shift_r;
   logic [DATA_WIDTH-1:0]  rb_r;
   logic [GAP_CNT_W-1:0]   gap_r;
   logic                   fall_stb_s;
   logic                   rise_stb_s;
   logic                   last_bit_stb_s;
   logic                   start_s;
   logic                   enable_s;

   assign start_s  = (state_r == LOAD);
   assign enable_s = (state_r == SHIFT);

   pixel_sclk_gen #(
      .DATA_WIDTH (DATA_WIDTH),
      .CLK_DIV    (CLK_DIV)
   ) u_sclk_gen (
      .CLK_IN       (CLK_IN),
      .RESET        (RESET),
      .start        (start_s),
      .enable       (enable_s),
      .abort        (STOP),
      .fall_stb     (fall_stb_s),
      .rise_stb     (rise_stb_s),
      .last_bit_stb (last_bit_stb_s),
      .s_clk        (S_CLK)
   );

   // Run-control FSM with the data, readback and gap registers and all outputs.
   always_ff @(posedge CLK_IN or posedge RESET) begin
      if (RESET) begin
         state_r  <= IDLE;
         shift_r  <= '0;
         rb_r     <= '0;
         gap_r    <= '0;
         RD_FIFO  <= 1'b0;
         S_DATA   <= 1'b0;
         RB_DATA  <= '0;
         RB_VALID <= 1'b0;
         WORD_CNT <= '0;
         ACTIVE   <= 1'b0;
         DONE     <= 1'b0;
      end else begin
         RD_FIFO  <= 1'b0;
         RB_VALID <= 1'b0;
         DONE     <= 1'b0;
         if (STOP) begin
            state_r <= IDLE;
            S_DATA  <= 1'b0;
            ACTIVE  <= 1'b0;
         end else begin
            case (state_r)
               IDLE: begin
                  if (START) begin
                     state_r  <= CHECK;
                     WORD_CNT <= '0;
                     ACTIVE   <= 1'b1;
                  end else begin
                     ACTIVE <= 1'b0;
                  end
               end
               CHECK: begin
                  if (EMPTY) begin
                     state_r <= IDLE;
                     DONE    <= 1'b1;
                     ACTIVE  <= 1'b0;
                  end else if (!BUSY) begin
                     state_r <= READ;
                     RD_FIFO <= 1'b1;
                  end else begin
                     state_r <= CHECK;
                  end
               end
               READ: state_r <= LAT;
               LAT:  state_r <= LOAD;
               LOAD: begin
                  shift_r <= DATA_IN;
                  rb_r    <= '0;
                  S_DATA  <= SHIFT_DIRECTION ? DATA_IN[DATA_WIDTH-1] : DATA_IN[0];
                  state_r <= SHIFT;
               end
               SHIFT: begin
                  if (last_bit_stb_s) begin
                     RB_DATA  <= rb_r;
                     RB_VALID <= 1'b1;
                     S_DATA   <= 1'b0;
                     gap_r    <= '0;
                     if (WORD_CNT != {WCNT_WIDTH{1'b1}}) begin
                        WORD_CNT <= WORD_CNT + WCNT_WIDTH'(1'b1);
                     end else begin
                        WORD_CNT <= WORD_CNT;
                     end
                     state_r <= (WORD_GAP > 32'sd0) ? GAP : CHECK;
                  end else if (fall_stb_s) begin
                     if (SHIFT_DIRECTION) begin
                        S_DATA  <= shift_r[DATA_WIDTH-2];
                        shift_r <= {shift_r[DATA_WIDTH-2:0], 1'b0};
                     end else begin
                        S_DATA  <= shift_r[1];
                        shift_r <= {1'b0, shift_r[DATA_WIDTH-1:1]};
                     end
                  end else if (rise_stb_s) begin
                     // readback follows the same bit order as the outgoing word
                     if (SHIFT_DIRECTION) begin
                        rb_r <= {rb_r[DATA_WIDTH-2:0], S_DIN};
                     end else begin
                        rb_r <= {S_DIN, rb_r[DATA_WIDTH-1:1]};
                     end
                  end else begin
                     state_r <= SHIFT;
                  end
               end
               GAP: begin
                  if (gap_r == GAP_LAST) begin
                     state_r <= CHECK;
                  end else begin
                     gap_r <= gap_r + GAP_CNT_W'(1'b1);
                  end
               end
               default: begin
                  state_r <= IDLE;
                  S_DATA  <= 1'b0;
                  ACTIVE  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
